// File: rtl/instqueue_pkg.sv
// Shared widths and default sizing for the fetch-to-decode instruction queue.
package instqueue_pkg;

    localparam int IDWidth               = 32;
    localparam int AddressWidth          = 32;
    localparam int DefaultQueueSize      = 16;
    localparam int DefaultQueueAddrWidth = 4;

endpackage

// File: rtl/instqueue.sv
// Circular instruction/PC FIFO between fetch and decode with a registered output,
// almost-full back-pressure, dispatcher stall and decoder/ROB flush.
module instqueue
    import instqueue_pkg::*;
#(
    parameter int InstQueueSize      = DefaultQueueSize,
    parameter int InstQueueAddrWidth = DefaultQueueAddrWidth
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    if_instqueue_en_in,
    input  logic [IDWidth-1:0]      if_instqueue_inst_in,
    input  logic [AddressWidth-1:0] if_instqueue_pc_in,
    output logic                    instqueue_if_full_out,
    input  logic                    decoder_instqueue_rst_in,
    input  logic                    rob_instqueue_rst_in,
    input  logic                    dispatcher_instqueue_stall_in,
    output logic                    instqueue_decoder_en_out,
    output logic [IDWidth-1:0]      instqueue_decoder_inst_out,
    output logic [AddressWidth-1:0] instqueue_decoder_pc_out
);

    localparam int CountWidth = InstQueueAddrWidth + 1;
    localparam logic [CountWidth-1:0] Capacity   = CountWidth'(InstQueueSize);
    localparam logic [CountWidth-1:0] AlmostFull = CountWidth'(InstQueueSize - 2);

    logic [IDWidth-1:0]      inst_mem [InstQueueSize];
    logic [AddressWidth-1:0] pc_mem   [InstQueueSize];

    logic [InstQueueAddrWidth-1:0] head;
    logic [InstQueueAddrWidth-1:0] tail;
    logic [CountWidth-1:0]         count;

    logic flush;
    logic pop;
    logic push;

    // A full queue still accepts a push when the same edge frees a slot.
    assign flush = decoder_instqueue_rst_in | rob_instqueue_rst_in;
    assign pop   = rdy_in & ~flush & ~dispatcher_instqueue_stall_in & (count != '0);
    assign push  = rdy_in & ~flush & if_instqueue_en_in & ((count < Capacity) | pop);

    // Two slots of headroom: one fetch already in flight plus the current push.
    assign instqueue_if_full_out = (count >= AlmostFull);

    always_ff @(posedge clk_in) begin
        if (push) begin
            inst_mem[tail] <= if_instqueue_inst_in;
            pc_mem[tail]   <= if_instqueue_pc_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head                       <= '0;
            tail                       <= '0;
            count                      <= '0;
            instqueue_decoder_en_out   <= 1'b0;
            instqueue_decoder_inst_out <= '0;
            instqueue_decoder_pc_out   <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                head                     <= '0;
                tail                     <= '0;
                count                    <= '0;
                instqueue_decoder_en_out <= 1'b0;
            end else begin
                instqueue_decoder_en_out <= pop;
                if (pop) begin
                    instqueue_decoder_inst_out <= inst_mem[head];
                    instqueue_decoder_pc_out   <= pc_mem[head];
                    head                       <= head + 1'b1;
                end
                if (push) begin
                    tail <= tail + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instqueue.sv
// Self-checking bench for instqueue: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_instqueue;
    import instqueue_pkg::*;

    logic                    clk_in = 1'b0;
    logic                    rst_in = 1'b0;
    logic                    rdy_in = 1'b0;
    logic                    if_en = 1'b0;
    logic [IDWidth-1:0]      if_inst = '0;
    logic [AddressWidth-1:0] if_pc = '0;
    logic                    dec_rst = 1'b0;
    logic                    rob_rst = 1'b0;
    logic                    stall = 1'b0;
    logic                    full_out;
    logic                    dec_en;
    logic [IDWidth-1:0]      dec_inst;
    logic [AddressWidth-1:0] dec_pc;

    int total = 0;
    int bad = 0;

    instqueue dut (
        .clk_in                        (clk_in),
        .rst_in                        (rst_in),
        .rdy_in                        (rdy_in),
        .if_instqueue_en_in            (if_en),
        .if_instqueue_inst_in          (if_inst),
        .if_instqueue_pc_in            (if_pc),
        .instqueue_if_full_out         (full_out),
        .decoder_instqueue_rst_in      (dec_rst),
        .rob_instqueue_rst_in          (rob_rst),
        .dispatcher_instqueue_stall_in (stall),
        .instqueue_decoder_en_out      (dec_en),
        .instqueue_decoder_inst_out    (dec_inst),
        .instqueue_decoder_pc_out      (dec_pc)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] instFor(input logic [31:0] pc);
        return {pc[15:0], 16'h0093};
    endfunction

    // Reference model: a plain FIFO of {inst,pc} with capacity 16 and a registered output.
    logic [63:0] mq [$];
    logic        m_en = 1'b0;
    logic [31:0] m_inst = '0;
    logic [31:0] m_pc = '0;

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mq.delete();
            m_en   = 1'b0;
            m_inst = '0;
            m_pc   = '0;
        end else if (rdy_in) begin
            if (dec_rst || rob_rst) begin
                mq.delete();
                m_en = 1'b0;
            end else begin
                if (!stall && mq.size() > 0) begin
                    {m_inst, m_pc} = mq.pop_front();
                    m_en = 1'b1;
                end else begin
                    m_en = 1'b0;
                end
                if (if_en) begin
                    if (mq.size() < 16)
                        mq.push_back({if_inst, if_pc});
                    else
                        $display("[TB] protocol violation: push of pc %h while full was dropped", if_pc);
                end
            end
        end
    end

    always @(negedge clk_in) begin
        checkOutput("cmp_en", 64'(dec_en), 64'(m_en));
        checkOutput("cmp_full", 64'(full_out), 64'(mq.size() >= 14));
        checkOutput("cmp_inst", 64'(dec_inst), 64'(m_inst));
        checkOutput("cmp_pc", 64'(dec_pc), 64'(m_pc));
    end

    task automatic applyStimulus(input logic en, input logic [31:0] pc, input logic [31:0] inst,
                                 input logic stall_v, input logic drst_v, input logic rrst_v,
                                 input logic rdy_v);
        @(negedge clk_in);
        if_en   = en;
        if_pc   = pc;
        if_inst = inst;
        stall   = stall_v;
        dec_rst = drst_v;
        rob_rst = rrst_v;
        rdy_in  = rdy_v;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input logic stall_v);
        applyStimulus(1'b0, 32'h0, 32'h0, stall_v, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic pushOne(input logic [31:0] pc, input logic stall_v);
        applyStimulus(1'b1, pc, instFor(pc), stall_v, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1 rst_in = 1'b1;
        #1;
        checkOutput("reset_en", 64'(dec_en), 64'd0);
        checkOutput("reset_pc", 64'(dec_pc), 64'd0);
        checkOutput("reset_inst", 64'(dec_inst), 64'd0);
        checkOutput("reset_full", 64'(full_out), 64'd0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        rdy_in = 1'b1;

        // Three back-to-back pushes drain one cycle behind, no bypass.
        applyStimulus(1'b1, 32'h0, 32'h00000013, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t1_no_bypass", 64'(dec_en), 64'd0);
        applyStimulus(1'b1, 32'h4, 32'h00100093, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t1_en0", 64'(dec_en), 64'd1);
        checkOutput("t1_pc0", 64'(dec_pc), 64'h0);
        checkOutput("t1_inst0", 64'(dec_inst), 64'h00000013);
        applyStimulus(1'b1, 32'h8, 32'h00200113, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t1_pc1", 64'(dec_pc), 64'h4);
        checkOutput("t1_inst1", 64'(dec_inst), 64'h00100093);
        idle(1'b0);
        checkOutput("t1_pc2", 64'(dec_pc), 64'h8);
        checkOutput("t1_inst2", 64'(dec_inst), 64'h00200113);
        idle(1'b0);
        checkOutput("t1_en_low", 64'(dec_en), 64'd0);

        // Fill to capacity under stall; a 17th push is dropped.
        for (int i = 0; i < 14; i++) begin
            pushOne(32'(i * 4), 1'b1);
            if (i == 12) checkOutput("t2_full_at13", 64'(full_out), 64'd0);
            if (i == 13) checkOutput("t2_full_at14", 64'(full_out), 64'd1);
        end
        pushOne(32'h38, 1'b1);
        pushOne(32'h3C, 1'b1);
        pushOne(32'h40, 1'b1);
        checkOutput("t2_full_at16", 64'(full_out), 64'd1);
        for (int k = 0; k < 17; k++) begin
            idle(1'b0);
            if (k < 16) begin
                checkOutput("t2_drain_en", 64'(dec_en), 64'd1);
                checkOutput("t2_drain_pc", 64'(dec_pc), 64'(k * 4));
            end else begin
                checkOutput("t2_dropped", 64'(dec_en), 64'd0);
            end
        end

        // Pointer wrap: fill 10, pop 8, push 12 more, drain 14 in order.
        for (int i = 0; i < 10; i++) pushOne(32'h200 + 32'(i * 4), 1'b1);
        for (int k = 0; k < 8; k++) begin
            idle(1'b0);
            checkOutput("t3_pop_pc", 64'(dec_pc), 64'(32'h200 + 32'(k * 4)));
        end
        for (int i = 0; i < 12; i++) pushOne(32'h228 + 32'(i * 4), 1'b1);
        checkOutput("t3_full", 64'(full_out), 64'd1);
        for (int k = 0; k < 14; k++) begin
            idle(1'b0);
            checkOutput("t3_wrap_pc", 64'(dec_pc), 64'(32'h220 + 32'(k * 4)));
            checkOutput("t3_wrap_inst", 64'(dec_inst), 64'(instFor(32'h220 + 32'(k * 4))));
        end
        idle(1'b0);
        checkOutput("t3_empty", 64'(dec_en), 64'd0);

        // JAL at 0x10 on the output with three younger entries; decoder flush.
        for (int i = 0; i < 4; i++) pushOne(32'h10 + 32'(i * 4), 1'b1);
        idle(1'b0);
        checkOutput("t4_jal_pc", 64'(dec_pc), 64'h10);
        checkOutput("t4_jal_en", 64'(dec_en), 64'd1);
        applyStimulus(1'b1, 32'h20, instFor(32'h20), 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("t4_flush_en", 64'(dec_en), 64'd0);
        checkOutput("t4_flush_pc_hold", 64'(dec_pc), 64'h10);
        idle(1'b0);
        checkOutput("t4_push_dropped", 64'(dec_en), 64'd0);

        // ROB flush during push+pop with five entries.
        for (int i = 0; i < 5; i++) pushOne(32'h300 + 32'(i * 4), 1'b1);
        applyStimulus(1'b1, 32'h400, instFor(32'h400), 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("t5_flush_en", 64'(dec_en), 64'd0);
        pushOne(32'h100, 1'b0);
        checkOutput("t5_no_bypass", 64'(dec_en), 64'd0);
        idle(1'b0);
        checkOutput("t5_after_en", 64'(dec_en), 64'd1);
        checkOutput("t5_after_pc", 64'(dec_pc), 64'h100);
        idle(1'b0);
        checkOutput("t5_empty", 64'(dec_en), 64'd0);

        // rdy_in low freezes everything, including the output pulse.
        pushOne(32'h500, 1'b0);
        pushOne(32'h504, 1'b0);
        pushOne(32'h508, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h600 + 32'(i * 4), instFor(32'h600), 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("t6_hold_en", 64'(dec_en), 64'd1);
            checkOutput("t6_hold_pc", 64'(dec_pc), 64'h504);
        end
        idle(1'b0);
        checkOutput("t6_resume_pc", 64'(dec_pc), 64'h508);
        idle(1'b0);
        checkOutput("t6_resume_empty", 64'(dec_en), 64'd0);

        // Asynchronous reset mid-cycle clears the output immediately.
        pushOne(32'h700, 1'b0);
        pushOne(32'h704, 1'b0);
        checkOutput("t7_pre_en", 64'(dec_en), 64'd1);
        #2 rst_in = 1'b1;
        #1;
        checkOutput("t7_async_en", 64'(dec_en), 64'd0);
        checkOutput("t7_async_pc", 64'(dec_pc), 64'd0);
        @(negedge clk_in);
        #1 rst_in = 1'b0;
        pushOne(32'h800, 1'b0);
        idle(1'b0);
        checkOutput("t7_recover_pc", 64'(dec_pc), 64'h800);
        idle(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instqueue.md
Name: instqueue

Overview:
Circular FIFO between instruction fetch and the decoder. Buffers fetched instruction/PC pairs and presents one per cycle on a registered output to the decoder. Applies back-pressure to fetch when nearly full and honours dispatcher stall. Flushes on a decoder JAL redirect or a ROB misprediction flush.

Parameters:
InstQueueSize, 16, number of entries; must be a power of two and at least 4
InstQueueAddrWidth, 4, log2(InstQueueSize); pointer width

Ports:
clk_in  input  1  clock; all state changes on the rising edge
rst_in  input  1  reset, asynchronous, active-high
rdy_in  input  1  global ready; when low, all state holds
if_instqueue_en_in  input  1  push request, one instruction per cycle
if_instqueue_inst_in  input  IDWidth(32)  instruction word to push
if_instqueue_pc_in  input  AddressWidth(32)  PC of the pushed instruction
instqueue_if_full_out  output  1  almost-full back-pressure to fetch
decoder_instqueue_rst_in  input  1  flush request from decoder (JAL redirect); combinational from the current output
rob_instqueue_rst_in  input  1  flush request from ROB (misprediction)
dispatcher_instqueue_stall_in  input  1  dispatcher cannot accept next cycle; inhibits pop
instqueue_decoder_en_out  output  1  output valid; registered, one-cycle pulse per instruction
instqueue_decoder_inst_out  output  IDWidth  instruction word, registered
instqueue_decoder_pc_out  output  AddressWidth  PC, registered

Behaviour:
- Reset, asynchronous: head=0, tail=0, count=0; en_out=0, inst_out=0, pc_out=0; full_out=0.
- rdy_in=0: pointers, count, storage and output registers all hold; inputs are ignored.
- Flush = decoder_instqueue_rst_in OR rob_instqueue_rst_in, sampled when rdy_in=1.
  - On flush: head=tail=count=0 and en_out=0 at the next edge.
  - Any same-cycle push or pop is discarded.
  - Flush has the highest priority.
- The instruction on the output during the cycle the decoder raises its flush is consumed (the JAL itself is dispatched). Only younger entries are dropped.
- Pop condition: rdy_in & !flush & !stall & count!=0.
  - Next edge: inst_out/pc_out = mem[head]; en_out=1; head=head+1, wrapping modulo InstQueueSize.
  - Otherwise en_out=0 at the next edge; inst_out/pc_out hold their last values.
- Push condition: rdy_in & !flush & en_in & (count<InstQueueSize | pop).
  - mem[tail]={inst,pc}; tail=tail+1, wrapping.
  - A push while full with no pop is dropped. This is a protocol violation; the bench flags it.
- Simultaneous push and pop: count unchanged. Push only: count+1. Pop only: count-1.
- Latency: a push at edge t can pop at edge t+1, so en_out is high in cycle t+1 at the earliest. Push into an empty queue does not bypass storage.
- full_out = (count >= InstQueueSize-2), combinational from registered count. This covers one in-flight fetch plus the current push.
- Throughput: one push and one pop per cycle sustained.
- Wrap-around: pointers are InstQueueAddrWidth bits and roll naturally. count is InstQueueAddrWidth+1 bits to distinguish full from empty.
- A stall arriving with en_out=1: the current output is already delivered. The next pop is inhibited, so en_out is 0 next cycle.

Decomposition:
- constant.vh gains InstQueueSize and InstQueueAddrWidth. It reuses IDWidth and AddressWidth.
- No sub-module. Storage is two reg arrays (inst, pc) inferred as distributed RAM, with no reset on the arrays.
- Target size is about 150 lines of RTL.

Test Plan:
- Reset then push PC 0x0,0x4,0x8 (insts 0x00000013, 0x00100093, 0x00200113), no stall -> en_out pulses on 3 consecutive cycles starting one cycle after the first push, with matching PC/inst.
- Push 14 entries with stall held -> full_out=1 once count=14. Push 2 more -> count=16. A 17th push with no pop is dropped. Release stall -> 16 pops in order, PC 0x0..0x3C.
- Fill 10 entries, pop 8, push 12 more -> head/tail wrap past 15. Output order is preserved and count=14.
- Output shows JAL at PC 0x10 with 3 younger entries queued. Decoder flush in the same cycle -> JAL is consumed, en_out=0 next cycle, count=0. The same-cycle push of PC 0x20 is dropped.
- rob_instqueue_rst_in during simultaneous push+pop with count=5 -> count=0 and en_out=0. The next push of PC 0x100 appears on the output one cycle later.
- rdy_in=0 for 3 cycles mid-stream with pushes offered -> no state change. Resume -> the sequence continues without loss. Asserting rst_in asynchronously mid-cycle -> en_out drops immediately.
